alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 87 ++++++++
 tb/tb_alu_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: registered N-bit ALU with a 2N-bit result and one-cycle latency.
// Optional divider on opcode 0011 is compiled in by defining ALU_DIV_EN.
module alu_unit #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [3:0]     ALUOp,
    output logic [2*N-1:0] result,
    output logic           data_valid
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;

    logic [2*N-1:0] result_d, result_q;
    logic           valid_d, valid_q;
    logic [2*N-1:0] a_ext, b_ext;

    // Zero-extended operands so add/sub/mul produce full 2N-bit results.
    always_comb begin
        a_ext = {{N{1'b0}}, A};
        b_ext = {{N{1'b0}}, B};
    end

    // Next result: hold when idle, zero on illegal opcodes.
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        if (enable) begin
            valid_d = 1'b1;
            case (ALUOp)
                OP_ADD: result_d = a_ext + b_ext;
                OP_SUB: result_d = a_ext - b_ext;
                OP_MUL: result_d = a_ext * b_ext;
`ifdef ALU_DIV_EN
                OP_DIV: begin
                    if (B == '0) begin
                        result_d = {A, {N{1'b1}}};
                    end else begin
                        result_d = {A % B, A / B};
                    end
                end
`endif
                OP_AND: result_d = {{N{1'b0}}, A & B};
                OP_OR:  result_d = {{N{1'b0}}, A | B};
                OP_XOR: result_d = {{N{1'b0}}, A ^ B};
                OP_NOT: result_d = {{N{1'b0}}, ~A};
                OP_SHL: result_d = {{(N-1){1'b0}}, A, 1'b0};
                OP_SHR: result_d = {{N{1'b0}}, 1'b0, A[N-1:1]};
                OP_CMP: result_d = {{(2*N-3){1'b0}},
                                    (A < B), (A > B), (A == B)};
                default: begin
                    result_d = '0;
                    valid_d  = 1'b0;
                end
            endcase
        end
    end

    // Result register; reset wins over enable and drops the sampled op.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result     = result_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed plus random checks of alu_unit (N=8),
// expected {data_valid,result} queued at drive time, popped after the edge.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [3:0]  ALUOp = '0;
    logic [15:0] result;
    logic        data_valid;

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] sb[$];
    logic [15:0] last_res = '0;

    alu_unit #(.N(8)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .A(A),
        .B(B),
        .ALUOp(ALUOp),
        .result(result),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

`ifdef ALU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    // Reference model using plain integer arithmetic.
    function automatic logic [16:0] model(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [3:0] op);
        int ai;
        int bi;
        int r;
        logic v;
        ai = int'(a);
        bi = int'(b);
        r = 0;
        v = 1'b1;
        case (op)
            4'd0: r = ai + bi;
            4'd1: r = ai - bi;
            4'd2: r = ai * bi;
            4'd3: begin
                if (!DIV_ON) begin
                    v = 1'b0;
                    r = 0;
                end else if (bi == 0) begin
                    r = ai * 256 + 255;
                end else begin
                    r = (ai % bi) * 256 + (ai / bi);
                end
            end
            4'd4: r = ai & bi;
            4'd5: r = ai | bi;
            4'd6: r = ai ^ bi;
            4'd7: r = 255 - ai;
            4'd8: r = ai * 2;
            4'd9: r = ai / 2;
            4'd10: r = (ai == bi) ? 1 : ((ai > bi) ? 2 : 4);
            default: begin
                v = 1'b0;
                r = 0;
            end
        endcase
        return {v, r[15:0]};
    endfunction

    // Drive one edge of stimulus, queue its expectation, check after edge.
    task automatic step(input logic r, input logic e,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [16:0] exp,
                        input string tag);
        logic [16:0] want;
        rst = r;
        enable = e;
        A = a;
        B = b;
        ALUOp = op;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            want = sb.pop_front();
            last_res = want[15:0];
            assert ({data_valid, result} === want) else begin
                miscompares++;
                $error("FAIL %s: got valid=%b result=%h, expected valid=%b result=%h",
                       tag, data_valid, result, want[16], want[15:0]);
            end
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rop;
        logic       ren;
        logic [16:0] e;

        @(negedge clk);
        step(1, 0, 8'h00, 8'h00, 4'h0, 17'h0_0000, "reset");
        step(0, 1, 8'hDA, 8'h2B, 4'h0, 17'h1_0105, "add");
        step(0, 1, 8'hDA, 8'h2B, 4'h1, 17'h1_00AF, "sub");
        step(0, 1, 8'h2B, 8'hDA, 4'h1, 17'h1_FF51, "sub_neg");
        step(0, 1, 8'h04, 8'h78, 4'h2, 17'h1_01E0, "mul");
        step(0, 1, 8'hFF, 8'hFF, 4'h2, 17'h1_FE01, "mul_max");
        step(0, 1, 8'hFF, 8'h01, 4'h0, 17'h1_0100, "add_carry");
        step(0, 0, 8'h12, 8'h34, 4'h5, {1'b0, last_res}, "hold_idle");
        step(0, 1, 8'hDA, 8'h2B, 4'h3,
             DIV_ON ? 17'h1_0305 : 17'h0_0000, "div");
        step(0, 1, 8'hDA, 8'h00, 4'h3,
             DIV_ON ? 17'h1_DAFF : 17'h0_0000, "div_by_zero");
        step(0, 1, 8'hDA, 8'h2B, 4'h4, 17'h1_000A, "and");
        step(0, 1, 8'hDA, 8'h2B, 4'h5, 17'h1_00FB, "or");
        step(0, 1, 8'hDA, 8'h2B, 4'h6, 17'h1_00F1, "xor");
        step(0, 1, 8'hDA, 8'h2B, 4'h7, 17'h1_0025, "not");
        step(0, 1, 8'hDA, 8'h2B, 4'hF, 17'h0_0000, "illegal");
        step(0, 0, 8'h99, 8'h77, 4'h0, 17'h0_0000, "hold_after_illegal");
        step(0, 1, 8'h80, 8'h00, 4'h8, 17'h1_0100, "shl_msb");
        step(0, 1, 8'h81, 8'h00, 4'h9, 17'h1_0040, "shr");
        step(0, 1, 8'h55, 8'h55, 4'hA, 17'h1_0001, "cmp_eq");
        step(0, 1, 8'h56, 8'h55, 4'hA, 17'h1_0002, "cmp_gt");
        step(0, 1, 8'h54, 8'h55, 4'hA, 17'h1_0004, "cmp_lt");
        step(0, 1, 8'h10, 8'h20, 4'hB, 17'h0_0000, "illegal_b");
        step(0, 1, 8'h10, 8'h20, 4'h0, 17'h1_0030, "add_again");
        step(1, 1, 8'hDA, 8'h2B, 4'h0, 17'h0_0000, "rst_with_enable");
        step(0, 0, 8'hDA, 8'h2B, 4'h0, 17'h0_0000, "idle_after_rst");
        step(0, 1, 8'h03, 8'h04, 4'h2, 17'h1_000C, "first_after_rst");

        for (int i = 0; i < 80; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            ren = ($urandom_range(0, 3) != 0);
            e = ren ? model(ra, rb, rop) : {1'b0, last_res};
            step(0, ren, ra, rb, rop, e, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
